icosoc_gpio_edgeirq: RTL and testbench
======================================

Name: icosoc_gpio_edgeirq

Overview:
- Input-conditioning stage that sits directly downstream of the GPIO pad ring. It consumes the raw pin input vector and produces debounced levels, latched edge events and a level interrupt.
- Register access uses the same ctrl_* slave handshake as other icosoc modules, so it hangs off the SoC peripheral bus.
- Intended use: buttons, encoders and external interrupt lines that need clean edges and a CPU interrupt.

Parameters:
- CLOCK_FREQ_HZ, 0: informational only; no logic depends on it.
- IO_LENGTH, 32: number of input bits handled, 1..32.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles required before the filtered level changes, >=1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  reset. Synchronous, active-high.
- ctrl_wr  input  1  write request, held until ctrl_done.
- ctrl_rd  input  1  read request, held until ctrl_done.
- ctrl_addr  input  8  byte register address.
- ctrl_wdat  input  32  write data.
- ctrl_rdat  output  32  read data, valid in the ctrl_done cycle.
- ctrl_done  output  1  one-cycle completion pulse.
- pin_in  input  IO_LENGTH  raw asynchronous pin levels from the pad ring.
- irq  output  1  registered level interrupt.

Behaviour:
- Reset values (reset high at a clock edge):
  - Synchronizers, filtered levels, debounce counters, rise/fall enables and pending are all 0.
  - ctrl_done and irq are 0; ctrl_rdat is 0.
- Synchronizer: 2-flop per bit (sync1, sync2). No other logic samples pin_in.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES+1):
  - if sync2 == filt: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: filt <= sync2 and cnt <= 0.
  - else: cnt <= cnt+1.
  - Latency: a clean pin change at edge E appears in sync2 at E+2 and in filt at E+2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes filt.
- Edge detect: computed in the same edge that updates filt.
  - rise_ev = filt 0->1 & rise_en; fall_ev = filt 1->0 & fall_en.
  - pending <= (pending & ~clear_mask) | rise_ev | fall_ev.
  - Set wins over a simultaneous W1C clear of the same bit.
- irq <= |pending, registered, so irq asserts one cycle after pending sets.
- Register map (ctrl_addr):
  - 0x00 filtered level, RO.
  - 0x04 rise_en, RW.
  - 0x08 fall_en, RW.
  - 0x0C pending; read returns it, write-1-to-clear.
  - 0x10 sync2 raw level, RO.
  - Bits above IO_LENGTH read 0 and ignore writes.
  - Unmapped addresses: writes ignored, reads return 0; ctrl_done still pulses.
  - Writes to enables do not retro-actively create or clear pending bits.
- Handshake:
  - When !reset, !ctrl_done and (ctrl_wr | ctrl_rd): ctrl_done <= 1 at the next edge and the access is performed at that edge.
  - The cycle after ctrl_done is high, ctrl_done <= 0 and a held request is ignored; each access therefore completes in exactly 1 cycle with at least 1 idle cycle between accesses.
  - ctrl_rdat holds 0 outside the done cycle.
  - Simultaneous ctrl_wr and ctrl_rd: the write is performed and the read returns the pre-write value.
- Reset mid-operation: an in-flight access is dropped with no ctrl_done. Counters clear; a pin held high after reset produces a filtered rise, but pending sets only if rise_en has been enabled by then.
- All-bits-simultaneous: any number of bits may set pending in one cycle; irq behaviour is unchanged.

Test Plan:
- Reset with pin_in=32'hFFFFFFFF, enables 0, DEBOUNCE_CYCLES=4 -> 0x00 reads 32'hFFFFFFFF from 6 cycles after reset release; pending=0; irq stays 0.
- rise_en=32'h1, pin_in[0] 0->1 at edge E -> filt[0]=1 at E+6; pending=1 at E+6; irq=1 at E+7; ctrl_done pulses 1 cycle after the request with 1 idle cycle between accesses.
- pin_in[3] glitch high for 3 cycles with DEBOUNCE_CYCLES=4, rise_en/fall_en=32'h8 -> filt[3] stays 0, pending=0, irq=0.
- Write 0x0C=32'h1 in the same edge that bit 0 sets from a fall event (fall_en=1) -> pending[0]=1 (set wins); next clear write -> pending=0, irq=0 one cycle later.
- Read 0x20 (unmapped) -> ctrl_rdat=0 with ctrl_done=1; write 0x20 -> no register changes.
- Hold ctrl_rd at 0x04 for 4 cycles -> ctrl_done pattern 1,0,1,0; assert reset during a pending request -> no ctrl_done, all registers 0.

Source files
------------

// File: rtl/icosoc_gpio_edgeirq_if.sv
// Peripheral control bus used by icosoc register blocks.
// A master raises ctrl_wr and/or ctrl_rd with ctrl_addr/ctrl_wdat and
// holds them until the slave answers with a one-cycle ctrl_done pulse.
// ctrl_rdat carries read data in the ctrl_done cycle.
//   ctrl_wr    write request
//   ctrl_rd    read request
//   ctrl_addr  byte register address
//   ctrl_wdat  write data
//   ctrl_rdat  read data (slave -> master)
//   ctrl_done  completion pulse (slave -> master)
interface icosoc_gpio_edgeirq_if;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic [7:0]  ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (
    output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    input  ctrl_rdat, ctrl_done
  );

  modport slave (
    input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    output ctrl_rdat, ctrl_done
  );
endinterface

// File: rtl/icosoc_gpio_edgeirq.sv
// GPIO input conditioning: two-flop synchronizer, per-bit debounce filter,
// enabled rise/fall edge latching into a pending register, and a level
// interrupt that is high while any pending bit is set.
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   ctrl      register bus (slave side)
//   i_pin_in  raw asynchronous pin levels
//   o_irq     registered interrupt, OR of all pending bits
// Register map: 0x00 filtered level (RO), 0x04 rise enable, 0x08 fall
// enable, 0x0C pending (write 1 to clear), 0x10 synchronized raw level (RO).
module icosoc_gpio_edgeirq #(
  parameter int CLOCK_FREQ_HZ   = 0,
  parameter int IO_LENGTH       = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  icosoc_gpio_edgeirq_if.slave  ctrl,
  input  logic [IO_LENGTH-1:0]  i_pin_in,
  output logic                  o_irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [IO_LENGTH-1:0]         r_sync1;
  logic [IO_LENGTH-1:0]         r_sync2;
  logic [IO_LENGTH-1:0]         r_filt;
  logic [IO_LENGTH-1:0][CW-1:0] r_cnt;
  logic [IO_LENGTH-1:0]         r_riseEn;
  logic [IO_LENGTH-1:0]         r_fallEn;
  logic [IO_LENGTH-1:0]         r_pending;
  logic                         r_irq;
  logic                         r_done;
  logic [31:0]                  r_rdat;

  logic [IO_LENGTH-1:0]         w_filtNext;
  logic [IO_LENGTH-1:0][CW-1:0] w_cntNext;
  logic [IO_LENGTH-1:0]         w_riseEv;
  logic [IO_LENGTH-1:0]         w_fallEv;
  logic [IO_LENGTH-1:0]         w_clearMask;
  logic                         w_access;
  logic                         w_wrEn;
  logic [31:0]                  w_readVal;

  // The filtered level only follows sync2 after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    w_filtNext = r_filt;
    w_cntNext  = r_cnt;
    for (int i = 0; i < IO_LENGTH; i++) begin
      if (r_sync2[i] == r_filt[i]) begin
        w_cntNext[i] = '0;
      end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        w_filtNext[i] = r_sync2[i];
        w_cntNext[i]  = '0;
      end else begin
        w_cntNext[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Edges are taken from the filter transition happening at this edge.
  assign w_riseEv = w_filtNext & ~r_filt & r_riseEn;
  assign w_fallEv = ~w_filtNext & r_filt & r_fallEn;

  // An access is accepted only when no completion is currently showing,
  // which forces one idle cycle between back-to-back requests.
  assign w_access    = !r_done && (ctrl.ctrl_wr || ctrl.ctrl_rd);
  assign w_wrEn      = w_access && ctrl.ctrl_wr;
  assign w_clearMask = (w_wrEn && ctrl.ctrl_addr == 8'h0C) ?
                       ctrl.ctrl_wdat[IO_LENGTH-1:0] : '0;

  // Read mux samples pre-write state, so a combined write+read returns
  // the old value; bits above IO_LENGTH stay zero.
  always_comb begin
    w_readVal = '0;
    case (ctrl.ctrl_addr)
      8'h00:   w_readVal[IO_LENGTH-1:0] = r_filt;
      8'h04:   w_readVal[IO_LENGTH-1:0] = r_riseEn;
      8'h08:   w_readVal[IO_LENGTH-1:0] = r_fallEn;
      8'h0C:   w_readVal[IO_LENGTH-1:0] = r_pending;
      8'h10:   w_readVal[IO_LENGTH-1:0] = r_sync2;
      default: w_readVal = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_filt    <= '0;
      r_cnt     <= '0;
      r_riseEn  <= '0;
      r_fallEn  <= '0;
      r_pending <= '0;
      r_irq     <= 1'b0;
      r_done    <= 1'b0;
      r_rdat    <= '0;
    end else begin
      r_sync1   <= i_pin_in;
      r_sync2   <= r_sync1;
      r_filt    <= w_filtNext;
      r_cnt     <= w_cntNext;
      // New events are OR-ed in after the clear so a set wins.
      r_pending <= (r_pending & ~w_clearMask) | w_riseEv | w_fallEv;
      r_irq     <= |r_pending;
      r_done    <= w_access;
      r_rdat    <= w_access ? w_readVal : 32'h0;
      if (w_wrEn && ctrl.ctrl_addr == 8'h04) begin
        r_riseEn <= ctrl.ctrl_wdat[IO_LENGTH-1:0];
      end
      if (w_wrEn && ctrl.ctrl_addr == 8'h08) begin
        r_fallEn <= ctrl.ctrl_wdat[IO_LENGTH-1:0];
      end
    end
  end

  assign ctrl.ctrl_done = r_done;
  assign ctrl.ctrl_rdat = r_rdat;
  assign o_irq          = r_irq;

endmodule

// File: tb/tb_icosoc_gpio_edgeirq.sv
// Self-checking bench for icosoc_gpio_edgeirq with DEBOUNCE_CYCLES=4.
// Register accesses come from a vector table and hand-written sequences;
// read expectations are queued when a request is driven and compared
// when ctrl_done shows up.
module tb_icosoc_gpio_edgeirq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pinIn;
  logic        irq;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expQ[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdat;
    logic        chk;
    logic [31:0] expRdat;
  } vec_t;

  vec_t vecs[12];

  icosoc_gpio_edgeirq_if bus ();

  icosoc_gpio_edgeirq #(
    .CLOCK_FREQ_HZ  (0),
    .IO_LENGTH      (32),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl    (bus),
    .i_pin_in(pinIn),
    .o_irq   (irq)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
    end
  endtask

  // One complete access: request for one edge, then one idle edge.
  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [7:0] addr, input logic [31:0] wdat,
                               input logic chk, input logic [31:0] expRdat);
    logic [31:0] expVal;
    bus.ctrl_wr   = wr;
    bus.ctrl_rd   = rd;
    bus.ctrl_addr = addr;
    bus.ctrl_wdat = wdat;
    if (chk) expQ.push_back(expRdat);
    tick();
    checkOutput($sformatf("done@%h", addr), {31'h0, bus.ctrl_done}, 32'h1);
    if (chk) begin
      expVal = expQ.pop_front();
      if (bus.ctrl_done)
        checkOutput($sformatf("rdat@%h", addr), bus.ctrl_rdat, expVal);
    end
    bus.ctrl_wr = 1'b0;
    bus.ctrl_rd = 1'b0;
    tick();
    checkOutput("doneIdle", {31'h0, bus.ctrl_done}, 32'h0);
    checkOutput("rdatIdle", bus.ctrl_rdat, 32'h0);
  endtask

  initial begin
    // Register-map vectors, applied while all pins are low.
    vecs[0]  = '{1'b1, 1'b0, 8'h04, 32'h0000_0005, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'h04, 32'h0,         1'b1, 32'h0000_0005};
    vecs[2]  = '{1'b1, 1'b0, 8'h08, 32'h0000_000A, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 8'h08, 32'h0,         1'b1, 32'h0000_000A};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 8'h20, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 8'h20, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 8'h04, 32'h0,         1'b1, 32'h0000_0005};
    vecs[8]  = '{1'b0, 1'b1, 8'h0C, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 8'h14, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 8'h04, 32'h0000_0003, 1'b1, 32'h0000_0005};
    vecs[11] = '{1'b0, 1'b1, 8'h04, 32'h0,         1'b1, 32'h0000_0003};

    bus.ctrl_wr   = 1'b0;
    bus.ctrl_rd   = 1'b0;
    bus.ctrl_addr = 8'h00;
    bus.ctrl_wdat = 32'h0;
    pinIn         = 32'hFFFF_FFFF;
    reset         = 1'b1;

    // Reset with every pin high; filter settles 6 edges after release.
    repeat (3) tick();
    checkOutput("rstDone", {31'h0, bus.ctrl_done}, 32'h0);
    checkOutput("rstRdat", bus.ctrl_rdat, 32'h0);
    checkOutput("rstIrq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    repeat (4) tick();
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h10, 32'h0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("rstIrqAfter", {31'h0, irq}, 32'h0);
    pinIn = 32'h0;
    repeat (10) tick();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdat,
                    vecs[i].chk, vecs[i].expRdat);
    end

    // Rising edge on bit 0: pending at E+6, irq at E+7.
    applyStimulus(1'b1, 1'b0, 8'h04, 32'h1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h08, 32'h0, 1'b0, 32'h0);
    pinIn[0] = 1'b1;
    repeat (4) tick();
    bus.ctrl_rd   = 1'b1;
    bus.ctrl_addr = 8'h0C;
    tick();
    checkOutput("riseDoneE5", {31'h0, bus.ctrl_done}, 32'h1);
    checkOutput("risePendE5", bus.ctrl_rdat, 32'h0);
    bus.ctrl_rd = 1'b0;
    tick();
    checkOutput("riseIrqE6", {31'h0, irq}, 32'h0);
    tick();
    checkOutput("riseIrqE7", {31'h0, irq}, 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h0C, 32'h1, 1'b0, 32'h0);
    checkOutput("riseIrqCleared", {31'h0, irq}, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'h0);

    // Three-cycle glitch on bit 3 must be filtered out.
    applyStimulus(1'b1, 1'b0, 8'h04, 32'h8, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h08, 32'h8, 1'b0, 32'h0);
    pinIn[3] = 1'b1;
    repeat (3) tick();
    pinIn[3] = 1'b0;
    repeat (10) tick();
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'h0);
    checkOutput("glitchIrq", {31'h0, irq}, 32'h0);

    // Clear write lands on the same edge as a fall event: set wins.
    applyStimulus(1'b1, 1'b0, 8'h04, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h08, 32'h1, 1'b0, 32'h0);
    pinIn[0] = 1'b0;
    repeat (5) tick();
    applyStimulus(1'b1, 1'b0, 8'h0C, 32'h1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'h1);
    checkOutput("setWinsIrq", {31'h0, irq}, 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h0C, 32'h1, 1'b0, 32'h0);
    checkOutput("setWinsIrqClr", {31'h0, irq}, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'h0);

    // All bits rising together.
    applyStimulus(1'b1, 1'b0, 8'h08, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h04, 32'hFFFF_FFFF, 1'b0, 32'h0);
    pinIn = 32'hFFFF_FFFF;
    repeat (10) tick();
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("allIrq", {31'h0, irq}, 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h0C, 32'hFFFF_FFFF, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'h0);
    checkOutput("allIrqClr", {31'h0, irq}, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h04, 32'h0, 1'b0, 32'h0);
    pinIn = 32'h0;
    repeat (10) tick();

    // Held read gives done pattern 1,0,1,0.
    applyStimulus(1'b1, 1'b0, 8'h04, 32'h5, 1'b0, 32'h0);
    bus.ctrl_rd   = 1'b1;
    bus.ctrl_addr = 8'h04;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("holdDone%0d", k), {31'h0, bus.ctrl_done},
                  (k % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("holdRdat%0d", k), bus.ctrl_rdat,
                  (k % 2 == 0) ? 32'h5 : 32'h0);
    end
    bus.ctrl_rd = 1'b0;
    tick();

    // Reset arriving with a request pending drops it and clears state.
    bus.ctrl_rd   = 1'b1;
    bus.ctrl_addr = 8'h04;
    reset         = 1'b1;
    tick();
    checkOutput("rstReqDone", {31'h0, bus.ctrl_done}, 32'h0);
    checkOutput("rstReqRdat", bus.ctrl_rdat, 32'h0);
    tick();
    checkOutput("rstReqDone2", {31'h0, bus.ctrl_done}, 32'h0);
    bus.ctrl_rd = 1'b0;
    reset       = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 8'h04, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h08, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'h0);
    checkOutput("rstReqIrq", {31'h0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
